npu_frame_sequencer: RTL and testbench

// Frame-level controller for the NPU datapath (line memory -> neuron unit -> pixel delay -> manipulation).

---
 rtl/npu_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_npu_frame_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_frame_sequencer.sv
// npu_frame_sequencer
//   Frame-level controller for the NPU datapath
//   (line memory -> neuron unit -> pixel delay -> manipulation).
//   Tracks the raster position of each accepted pixel and walks the frame
//   through IDLE/FILL/RUN/DRAIN/DONE. It also tags the output pixels whose
//   KERNEL x KERNEL window is fully populated. The tag is aligned to the
//   datapath delay.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high
//   de_in         in   pixel valid at the NPU input
//   col           out  column of the next accepted pixel
//   row           out  line of the next accepted pixel
//   state_o       out  0 IDLE, 1 FILL, 2 RUN, 3 DRAIN, 4 DONE
//   window_valid  out  output pixel this cycle has a complete window
//   pix_valid     out  de_in delayed PIPE_DELAY cycles
//   line_end      out  pulse the cycle after the last pixel of a line
//   frame_done    out  pulse while in DONE
//   overrun       out  sticky: de_in seen during DRAIN or DONE
module npu_frame_sequencer #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int KERNEL     = 7,
  parameter int PIPE_DELAY = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          de_in,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic [2:0]                    state_o,
  output logic                          window_valid,
  output logic                          pix_valid,
  output logic                          line_end,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  // The drain counter only ever holds PIPE_DELAY-1 down to 0
  localparam int DW = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_WIN    = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_WIN    = RW'(KERNEL - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DELAY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic                  line_end_q, line_end_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic [PIPE_DELAY-1:0] tag_sr_q, tag_sr_d;
  logic [PIPE_DELAY-1:0] de_sr_q, de_sr_d;

  logic accept;
  logic tag;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    line_end_d   = 1'b0;
    overrun_d    = overrun_q;

    accept = de_in && ((state_q == ST_IDLE) || (state_q == ST_FILL) ||
                       (state_q == ST_RUN));
    // Window completeness uses the position of the pixel being accepted
    tag    = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);

    case (state_q)
      ST_IDLE, ST_FILL, ST_RUN: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d      = '0;
            line_end_d = 1'b1;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_LOAD;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          // Before RUN, the next line index decides whether enough lines
          // are buffered for a full window
          if ((state_d != ST_DRAIN) && (state_q != ST_RUN)) begin
            state_d = (row_d >= ROW_WIN) ? ST_RUN : ST_FILL;
          end
        end
      end
      ST_DRAIN: begin
        if (de_in) overrun_d = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - DW'(1);
      end
      ST_DONE: begin
        if (de_in) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    frame_done_d = (state_d == ST_DONE);

    // Free-running delay lines so the final pixels still emerge while draining
    tag_sr_d    = tag_sr_q;
    de_sr_d     = de_sr_q;
    tag_sr_d[0] = tag;
    de_sr_d[0]  = de_in;
    for (int i = 1; i < PIPE_DELAY; i++) begin
      tag_sr_d[i] = tag_sr_q[i-1];
      de_sr_d[i]  = de_sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      tag_sr_q     <= '0;
      de_sr_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      line_end_q   <= line_end_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      tag_sr_q     <= tag_sr_d;
      de_sr_q      <= de_sr_d;
    end
  end

  assign col          = col_q;
  assign row          = row_q;
  assign state_o      = state_q;
  assign window_valid = tag_sr_q[PIPE_DELAY-1];
  assign pix_valid    = de_sr_q[PIPE_DELAY-1];
  assign line_end     = line_end_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_npu_frame_sequencer.sv
// tb_npu_frame_sequencer
//   Bench for npu_frame_sequencer. The main instance is 10x9 with K=7 and
//   D=7. A second instance uses the default 64x64 geometry.
module tb_npu_frame_sequencer;

  localparam int W = 10;
  localparam int H = 9;
  localparam int K = 7;
  localparam int D = 7;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       de_in;
  logic [3:0] col;
  logic [3:0] row;
  logic [2:0] state_o;
  logic       window_valid, pix_valid, line_end, frame_done, overrun;

  logic       big_de;
  logic [5:0] big_col;
  logic [5:0] big_row;
  logic [2:0] big_state;
  logic       big_win, big_pix, big_le, big_fd, big_ovr;

  npu_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K), .PIPE_DELAY(D)
  ) dut (
    .clk(clk), .reset(reset), .de_in(de_in), .col(col), .row(row),
    .state_o(state_o), .window_valid(window_valid), .pix_valid(pix_valid),
    .line_end(line_end), .frame_done(frame_done), .overrun(overrun)
  );

  npu_frame_sequencer dut_big (
    .clk(clk), .reset(reset), .de_in(big_de), .col(big_col), .row(big_row),
    .state_o(big_state), .window_valid(big_win), .pix_valid(big_pix),
    .line_end(big_le), .frame_done(big_fd), .overrun(big_ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit win;
  } sb_item_t;
  sb_item_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  int m_col = 0;
  int m_row = 0;

  int win_cnt = 0, pix_cnt = 0, le_cnt = 0, fd_cnt = 0, fd_cyc = -1;
  int bwin_cnt = 0, bpix_cnt = 0, bfd_cnt = 0;

  // One clock of stimulus. Entered and left 1 time unit after a rising edge.
  // Each driven pixel is pushed as an expected output D cycles later.
  // The falling edge pops and compares whatever the pipeline produces.
  task automatic step(input bit de, input bit acc);
    sb_item_t it;
    de_in = de;
    if (de) begin
      it.due = cyc + D;
      it.win = acc && (m_row >= K - 1) && (m_col >= K - 1);
      sb.push_back(it);
    end
    if (acc) begin
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      n_cmp++;
      if (pix_valid !== 1'b1 || sb[0].due != cyc) begin
        n_err++;
        $display("FAIL sb_pix cyc=%0d got pix_valid=%b want 1 due=%0d", cyc, pix_valid, sb[0].due);
      end
      n_cmp++;
      if (window_valid !== sb[0].win) begin
        n_err++;
        $display("FAIL sb_win cyc=%0d got window_valid=%b want %b", cyc, window_valid, sb[0].win);
      end
      void'(sb.pop_front());
    end else begin
      n_cmp++;
      if (pix_valid !== 1'b0 || window_valid !== 1'b0) begin
        n_err++;
        $display("FAIL sb_idle cyc=%0d got pix=%b win=%b want 0 0", cyc, pix_valid, window_valid);
      end
    end
    if (window_valid === 1'b1) win_cnt++;
    if (pix_valid === 1'b1) pix_cnt++;
    if (line_end === 1'b1) le_cnt++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (big_win === 1'b1) bwin_cnt++;
    if (big_pix === 1'b1) bpix_cnt++;
    if (big_fd === 1'b1) bfd_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Idles until frame_done appears (bounded), then idles `extra` more cycles
  task automatic drain(input int extra, output bit seen);
    int f0;
    f0 = fd_cnt;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 1'b0);
      if (fd_cnt != f0) seen = 1'b1;
    end
    repeat (extra) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    de_in = 1'b0;
    sb.delete();
    m_col = 0;
    m_row = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    de_in = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || col !== 4'd0 || row !== 4'd0) begin
      n_err++;
      $display("FAIL reset_pos got st=%0d col=%0d row=%0d want 0 0 0", state_o, col, row);
    end
    n_cmp++;
    if ({window_valid, pix_valid, line_end, frame_done, overrun} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 00000",
               {window_valid, pix_valid, line_end, frame_done, overrun});
    end
    de_in = 1'b0;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_continuous();
    int w0, p0, l0, f0, last;
    bit seen;
    w0 = win_cnt; p0 = pix_cnt; l0 = le_cnt; f0 = fd_cnt;
    last = 0;
    for (int i = 0; i < W * H; i++) begin
      if (i == W * H - 1) last = cyc;
      step(1'b1, 1'b1);
      if (i == 0) begin
        n_cmp++;
        if (state_o !== 3'd1) begin
          n_err++;
          $display("FAIL cont_fill got state=%0d want 1", state_o);
        end
      end
      if (i == 58 || i == 59) begin
        n_cmp++;
        if (state_o !== ((i == 58) ? 3'd1 : 3'd2)) begin
          n_err++;
          $display("FAIL cont_run i=%0d got state=%0d want %0d", i, state_o, (i == 58) ? 1 : 2);
        end
      end
      if (i == 44) begin
        n_cmp++;
        if (col !== 4'd5 || row !== 4'd4) begin
          n_err++;
          $display("FAIL cont_pos got col=%0d row=%0d want 5 4", col, row);
        end
      end
    end
    n_cmp++;
    if (state_o !== 3'd3 || col !== 4'd0 || row !== 4'd0) begin
      n_err++;
      $display("FAIL cont_drain got st=%0d col=%0d row=%0d want 3 0 0", state_o, col, row);
    end
    drain(3, seen);
    n_cmp++;
    if (!seen || fd_cyc != last + D + 1) begin
      n_err++;
      $display("FAIL cont_done_time got seen=%0d cyc=%0d want cyc=%0d", seen, fd_cyc, last + D + 1);
    end
    n_cmp++;
    if (win_cnt - w0 != 12 || pix_cnt - p0 != 90 || le_cnt - l0 != 9 || fd_cnt - f0 != 1) begin
      n_err++;
      $display("FAIL cont_counts got win=%0d pix=%0d le=%0d fd=%0d want 12 90 9 1",
               win_cnt - w0, pix_cnt - p0, le_cnt - l0, fd_cnt - f0);
    end
    n_cmp++;
    if (state_o !== 3'd0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL cont_end got st=%0d ovr=%b want 0 0", state_o, overrun);
    end
  endtask

  task automatic test_gaps();
    int w0, p0, f0;
    bit seen;
    w0 = win_cnt; p0 = pix_cnt; f0 = fd_cnt;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      if (i == 13 || i == 70) begin
        n_cmp++;
        if (col !== 4'(m_col) || row !== 4'(m_row)) begin
          n_err++;
          $display("FAIL gap_hold i=%0d got col=%0d row=%0d want %0d %0d", i, col, row, m_col, m_row);
        end
      end
    end
    drain(3, seen);
    n_cmp++;
    if (!seen || win_cnt - w0 != 12 || pix_cnt - p0 != 90 || fd_cnt - f0 != 1) begin
      n_err++;
      $display("FAIL gap_counts got win=%0d pix=%0d fd=%0d want 12 90 1",
               win_cnt - w0, pix_cnt - p0, fd_cnt - f0);
    end
  endtask

  task automatic test_overrun();
    int w0, p0, f0;
    bit seen;
    w0 = win_cnt; p0 = pix_cnt; f0 = fd_cnt;
    repeat (W * H) step(1'b1, 1'b1);
    for (int i = 0; i < D + 1; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (col !== 4'd0 || row !== 4'd0) begin
        n_err++;
        $display("FAIL ovr_pos i=%0d got col=%0d row=%0d want 0 0", i, col, row);
      end
    end
    repeat (10) step(1'b0, 1'b0);
    n_cmp++;
    if (overrun !== 1'b1 || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL ovr_flag got ovr=%b st=%0d want 1 0", overrun, state_o);
    end
    n_cmp++;
    if (win_cnt - w0 != 12 || pix_cnt - p0 != 98 || fd_cnt - f0 != 1) begin
      n_err++;
      $display("FAIL ovr_counts got win=%0d pix=%0d fd=%0d want 12 98 1",
               win_cnt - w0, pix_cnt - p0, fd_cnt - f0);
    end
    repeat (W * H) step(1'b1, 1'b1);
    drain(2, seen);
    n_cmp++;
    if (!seen || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky got seen=%0d ovr=%b want 1 1", seen, overrun);
    end
    do_reset();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_midreset();
    repeat (45) step(1'b1, 1'b1);
    n_cmp++;
    if (col !== 4'd5 || row !== 4'd4 || state_o !== 3'd1) begin
      n_err++;
      $display("FAIL mid_pos got col=%0d row=%0d st=%0d want 5 4 1", col, row, state_o);
    end
    reset = 1'b1;
    de_in = 1'b1;
    sb.delete();
    m_col = 0;
    m_row = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || col !== 4'd0 || row !== 4'd0 || pix_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got st=%0d col=%0d row=%0d pix=%b want 0 0 0 0",
               state_o, col, row, pix_valid);
    end
    reset = 1'b0;
    de_in = 1'b0;
    repeat (D + 2) step(1'b0, 1'b0);
    test_continuous();
  endtask

  task automatic test_back_to_back();
    int w0, p0, l0, f0, last;
    bit seen;
    repeat (W * H) step(1'b1, 1'b1);
    drain(0, seen);
    n_cmp++;
    if (!seen || state_o !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_first got seen=%0d st=%0d want 1 0", seen, state_o);
    end
    w0 = win_cnt; p0 = pix_cnt; l0 = le_cnt; f0 = fd_cnt;
    last = 0;
    for (int i = 0; i < W * H; i++) begin
      if (i == W * H - 1) last = cyc;
      step(1'b1, 1'b1);
      if (i == 0) begin
        n_cmp++;
        if (state_o !== 3'd1 || col !== 4'd1) begin
          n_err++;
          $display("FAIL b2b_start got st=%0d col=%0d want 1 1", state_o, col);
        end
      end
    end
    drain(3, seen);
    n_cmp++;
    if (!seen || fd_cyc != last + D + 1 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done got seen=%0d cyc=%0d ovr=%b want 1 %0d 0", seen, fd_cyc, overrun, last + D + 1);
    end
    n_cmp++;
    if (win_cnt - w0 != 12 || pix_cnt - p0 != 90 || le_cnt - l0 != 9 || fd_cnt - f0 != 1) begin
      n_err++;
      $display("FAIL b2b_counts got win=%0d pix=%0d le=%0d fd=%0d want 12 90 9 1",
               win_cnt - w0, pix_cnt - p0, le_cnt - l0, fd_cnt - f0);
    end
  endtask

  task automatic test_defaults();
    int b0;
    bit seen;
    b0 = bfd_cnt;
    big_de = 1'b1;
    repeat (4096) step(1'b0, 1'b0);
    big_de = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 1'b0);
      if (bfd_cnt != b0) seen = 1'b1;
    end
    repeat (2) step(1'b0, 1'b0);
    n_cmp++;
    if (!seen || bwin_cnt != 3364 || bpix_cnt != 4096 || bfd_cnt != 1) begin
      n_err++;
      $display("FAIL big_counts got win=%0d pix=%0d fd=%0d want 3364 4096 1", bwin_cnt, bpix_cnt, bfd_cnt);
    end
    n_cmp++;
    if (big_ovr !== 1'b0 || big_state !== 3'd0) begin
      n_err++;
      $display("FAIL big_end got ovr=%b st=%0d want 0 0", big_ovr, big_state);
    end
  endtask

  initial begin
    reset  = 1'b1;
    de_in  = 1'b0;
    big_de = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_continuous();
    test_gaps();
    test_overrun();
    test_midreset();
    do_reset();
    test_back_to_back();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
